// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg -- shared definitions for the add_pipe arithmetic pipeline.
//
// Contents:
//   DEFAULT_BIT_WIDTH  default operand/result width of add_pipe
//   PAYLOAD_W          width of one stage payload at the default width
//   payload_width()    payload width {y, ovf} for an arbitrary operand width
//   payload_t          stage payload {y, ovf} at the default width
//
// Optional feature macro used by add_pipe: ADD_PIPE_SAT_EN (saturating add).
package add_pipe_pkg;

    localparam int unsigned DEFAULT_BIT_WIDTH = 8;
    localparam int unsigned PAYLOAD_W         = DEFAULT_BIT_WIDTH + 1;

    // Each stage carries the result plus its carry/overflow flag.
    function automatic int unsigned payload_width(input int unsigned bit_width);
        return bit_width + 1;
    endfunction

    // Default-width view of the stage payload. add_pipe declares the same
    // layout locally so that it follows its BIT_WIDTH parameter.
    typedef struct packed {
        logic [DEFAULT_BIT_WIDTH-1:0] y;
        logic                         ovf;
    } payload_t;

endpackage

// File: rtl/add_pipe_stage.sv
// add_pipe_stage -- one elastic register stage of the add_pipe pipeline.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset (clears valid and payload)
//   up_valid  upstream beat present
//   up_data   upstream payload (W bits)
//   ready     this stage may load this cycle (empty, or downstream taking)
//   valid     stage holds a beat
//   data      stage payload
//
// When ready=1 the stage takes the upstream valid; the payload only loads
// for a real beat so that bubbles do not disturb the held value.
module add_pipe_stage #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/add_pipe.sv
// add_pipe -- unsigned adder / accumulator followed by DEPTH elastic stages
// with valid/ready handshake and full-throughput back-pressure.
//
// Parameters:
//   BIT_WIDTH  operand and result width (>=2)
//   DEPTH      register stages between acceptance and output (>=1)
//
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_valid    operands present          in_ready   operands accepted this cycle
//   a0, a1      unsigned operands (a1 unused in accumulate mode)
//   acc_mode    0: y = a0 + a1            1: y = a0 + acc
//   acc_clr     with an accepted beat, use acc = 0 for this beat
//   out_valid   result present            out_ready  consumer takes result
//   y, ovf      result and carry-out of its add
//
// Optional feature: define ADD_PIPE_SAT_EN to saturate y to all-ones on
// carry-out (ovf still 1, and acc keeps the saturated value). Without it
// the sum wraps modulo 2^BIT_WIDTH.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a0,
    input  logic [BIT_WIDTH-1:0] a1,
    input  logic                 acc_mode,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] y,
    output logic                 ovf
);

    localparam int unsigned PW = payload_width(BIT_WIDTH);

    typedef struct packed {
        logic [BIT_WIDTH-1:0] y;
        logic                 ovf;
    } stage_payload_t;

    logic [BIT_WIDTH-1:0] acc_q;
    logic [BIT_WIDTH-1:0] acc_d;
    logic [BIT_WIDTH-1:0] operand_b;
    logic [BIT_WIDTH:0]   sum;
    logic                 accept;
    stage_payload_t       head_payload;

    logic [DEPTH-1:0]     stage_valid;
    logic [DEPTH-1:0]     stage_ready;
    stage_payload_t       stage_data [DEPTH];

    assign in_ready = stage_ready[0];
    assign accept   = in_valid & in_ready;

    // Stage-0 arithmetic and accumulator next state.
    always_comb begin
        operand_b = a1;
        if (acc_mode) begin
            operand_b = acc_clr ? '0 : acc_q;
        end
        sum              = {1'b0, a0} + {1'b0, operand_b};
        head_payload.ovf = sum[BIT_WIDTH];
`ifdef ADD_PIPE_SAT_EN
        head_payload.y   = sum[BIT_WIDTH] ? '1 : sum[BIT_WIDTH-1:0];
`else
        head_payload.y   = sum[BIT_WIDTH-1:0];
`endif
        // Both modes seed the accumulator with the produced result.
        acc_d = accept ? head_payload.y : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic           up_valid;
        stage_payload_t up_data;

        if (gi == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = head_payload;
        end else begin : g_link
            assign up_valid = stage_valid[gi-1];
            assign up_data  = stage_data[gi-1];
        end

        // Unrolled form of ready_i = ~valid_i | ready_(i+1): a stage can load
        // unless it and every stage after it are full while the consumer stalls.
        assign stage_ready[gi] = out_ready | ~(&stage_valid[DEPTH-1:gi]);

        add_pipe_stage #(
            .W (PW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_data  (up_data),
            .ready    (stage_ready[gi]),
            .valid    (stage_valid[gi]),
            .data     (stage_data[gi])
        );
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign y         = stage_data[DEPTH-1].y;
    assign ovf       = stage_data[DEPTH-1].ovf;

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe -- self-checking bench for add_pipe.
// Three instances (DEPTH 2, 1, 4, BIT_WIDTH 8) share stimulus. Each has a
// scoreboard fed on accept and drained on output transfer; directed timing
// checks are made against the DEPTH=2 instance (index 0).
module tb_add_pipe;

    localparam int W     = 8;
    localparam int N_DUT = 3;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         acc_mode  = 1'b0;
    logic         acc_clr   = 1'b0;
    logic [W-1:0] a0        = '0;
    logic [W-1:0] a1        = '0;

    logic         in_ready  [N_DUT];
    logic         out_valid [N_DUT];
    logic [W-1:0] y         [N_DUT];
    logic         ovf       [N_DUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference result {ovf, y} for a + b.
    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ADD_PIPE_SAT_EN
        if (s[W]) s = {1'b1, {W{1'b1}}};
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

        logic [W:0]   sb [$];
        logic [W-1:0] acc_m = '0;

        add_pipe #(
            .BIT_WIDTH (W),
            .DEPTH     (D)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[gi]),
            .a0        (a0),
            .a1        (a1),
            .acc_mode  (acc_mode),
            .acc_clr   (acc_clr),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready),
            .y         (y[gi]),
            .ovf       (ovf[gi])
        );

        // Inputs are stable at the falling edge, so what is seen here is
        // what the next rising edge will transfer.
        always @(negedge clk) begin
            logic [W:0]   e;
            logic [W-1:0] b;
            if (rst) begin
                sb.delete();
                acc_m = '0;
            end else begin
                if (out_valid[gi] && out_ready) begin
                    checks++;
                    assert (sb.size() > 0) else begin
                        errors++;
                        $error("FAIL sb%0d_extra observed=y%0d expected=no_output", gi, y[gi]);
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        $display("dut%0d out y=%0d ovf=%0b exp_y=%0d exp_ovf=%0b",
                                 gi, y[gi], ovf[gi], e[W-1:0], e[W]);
                        checks++;
                        assert ({ovf[gi], y[gi]} === e) else begin
                            errors++;
                            $error("FAIL sb%0d_data observed=%0h expected=%0h", gi, {ovf[gi], y[gi]}, e);
                        end
                    end
                end
                if (in_valid && in_ready[gi]) begin
                    b = acc_mode ? (acc_clr ? '0 : acc_m) : a1;
                    e = model_sum(a0, b);
                    sb.push_back(e);
                    acc_m = e[W-1:0];
                end
            end
        end
    end

    initial begin
        int nxt;
        int accepts;

        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid[0], 1'b0);
        chk("rst_y", y[0], 8'd0);
        chk("rst_ovf", ovf[0], 1'b0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready[0], 1'b1);
        chk("post_rst_out_valid", out_valid[0], 1'b0);

        // Plain add, latency of DEPTH cycles from presentation
        acc_mode = 1'b0; a0 = 8'd3; a1 = 8'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_not_early", out_valid[0], 1'b0);
        step();
        chk("lat_valid", out_valid[0], 1'b1);
        chk("add_3_4_y", y[0], 8'd7);
        chk("add_3_4_ovf", ovf[0], 1'b0);

        // Carry-out
        a0 = 8'd200; a1 = 8'd100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
`ifdef ADD_PIPE_SAT_EN
        chk("add_200_100_y", y[0], 8'd255);
`else
        chk("add_200_100_y", y[0], 8'd44);
`endif
        chk("add_200_100_ovf", ovf[0], 1'b1);

        // Accumulate 10, +20, +30 (a1 must be ignored)
        acc_mode = 1'b1; acc_clr = 1'b1; a0 = 8'd10; a1 = 8'd99; in_valid = 1'b1;
        step();
        acc_clr = 1'b0; a0 = 8'd20;
        step();
        a0 = 8'd30;
        chk("acc_beat1", y[0], 8'd10);
        step();
        in_valid = 1'b0;
        chk("acc_beat2", y[0], 8'd30);
        step();
        chk("acc_beat3", y[0], 8'd60);
        step();

        // Back-pressure: 5 stalled cycles while streaming 1..6
        acc_mode = 1'b0; a1 = 8'd0; out_ready = 1'b0; nxt = 1; accepts = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; a0 = 8'(nxt);
            #1;
            if (in_ready[0]) begin
                accepts++;
                nxt++;
            end
            if (c >= 2) begin
                chk("bp_in_ready_low", in_ready[0], 1'b0);
                chk("bp_y_held", y[0], 8'd1);
            end
            step();
        end
        chk("bp_accepts", accepts, 2);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && nxt <= 6; c++) begin
            in_valid = 1'b1; a0 = 8'(nxt);
            #1;
            if (in_ready[0]) nxt++;
            step();
        end
        chk("bp_all_sent", nxt, 7);
        in_valid = 1'b0;
        repeat (6) step();

        // Full throughput with simultaneous accept and output transfer
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; a0 = 8'(c * 17); a1 = 8'(c * 29);
            #1;
            chk("thru_in_ready", in_ready[0], 1'b1);
            if (c >= 2) chk("thru_out_valid", out_valid[0], 1'b1);
            step();
        end

        // Asynchronous reset mid-stream, between clock edges
        #2;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("arst_out_valid", out_valid[0], 1'b0);
        chk("arst_y", y[0], 8'd0);
        chk("arst_ovf", ovf[0], 1'b0);
        step();
        rst = 1'b0;
        step();
        acc_mode = 1'b1; acc_clr = 1'b0; a0 = 8'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("arst_acc_cleared_valid", out_valid[0], 1'b1);
        chk("arst_acc_cleared_y", y[0], 8'd5);
        step();

        // Random stress on all three depths
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            acc_mode  = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 5) == 0);
            a0        = 8'($urandom_range(0, 255));
            a1        = 8'($urandom_range(0, 255));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) step();

        chk("drain_dut0_idle", out_valid[0], 1'b0);
        chk("drain_dut1_idle", out_valid[1], 1'b0);
        chk("drain_dut2_idle", out_valid[2], 1'b0);
        chk("drain_sb0_empty", g_dut[0].sb.size(), 0);
        chk("drain_sb1_empty", g_dut[1].sb.size(), 0);
        chk("drain_sb2_empty", g_dut[2].sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised successor to the team's single-register adder path.
- Computes A0+A1, or a running accumulation, and carries the result through DEPTH elastic register stages with valid/ready handshake and back-pressure.
- Used as the generic arithmetic pipeline between producer/consumer blocks in the datapath.

Parameters:
- BIT_WIDTH, 8, operand and result width (>=2).
- DEPTH, 2, number of register stages between input acceptance and output (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; one clock domain, reset is asynchronous and active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a0  input  BIT_WIDTH  operand 0 (unsigned).
- a1  input  BIT_WIDTH  operand 1 (unsigned); ignored in accumulate mode.
- acc_mode  input  1  0 = y gets a0+a1; 1 = y gets a0+acc.
- acc_clr  input  1  with an accepted beat, use acc=0 for this beat's sum.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- y  output  BIT_WIDTH  result.
- ovf  output  1  carry-out of the unsigned add for this result.

Behaviour:
- Reset, asserted asynchronously: all stage valids=0, stage data=0, acc=0, out_valid=0, y=0, ovf=0, in_ready=1 once rst deasserts.
- Accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Stage-0 combinational sum:
  - Operand B = a1 when acc_mode=0.
  - Operand B = (acc_clr ? 0 : acc) when acc_mode=1.
  - Compute a (BIT_WIDTH+1)-bit sum; ovf = sum[BIT_WIDTH]; y = sum[BIT_WIDTH-1:0].
- acc updates only on accept: acc <= y value produced for that beat, in both modes. This means mode 0 also seeds the accumulator. acc is unchanged when no accept occurs, including under stall.
- Elastic stage i (i=0..DEPTH-1): holds valid_i, {y,ovf}_i.
  - ready_i = ~valid_i | ready_(i+1). The last stage uses ready_DEPTH = out_ready. in_ready = ready_0.
  - On a clock edge with ready_i=1: valid_i <= upstream valid, and data loads when upstream valid=1.
  - When ready_i=0 the stage holds its contents.
- Ready is a combinational chain through all stages. This gives full throughput of one beat per cycle; no bubbles are inserted.
- Latency: with out_ready held at 1, a beat accepted at edge N appears on out_valid/y at edge N+DEPTH-1, visible in the cycle after that edge. Equivalently, DEPTH cycles after presentation.
- Output stability: while out_valid=1 & out_ready=0, y and ovf hold constant. No beat is dropped or duplicated.
- Full pipeline (all valid_i=1) with out_ready=0: in_ready=0, and a0/a1 are ignored.
- Simultaneous transfer: out transfer and accept in the same cycle on a full pipeline are legal; occupancy is unchanged.
- Wrap-around: sums exceeding 2^BIT_WIDTH-1 wrap modulo 2^BIT_WIDTH with ovf=1, unless the optional feature below is enabled.
- acc_clr without accept has no effect.
- Reset mid-operation: all in-flight beats are discarded immediately (async) and acc=0. There is no partial output.

Optional Feature:
- Macro ADD_PIPE_SAT_EN.
- Defined: when sum[BIT_WIDTH]=1, y saturates to all-ones (2^BIT_WIDTH-1) and ovf=1. acc stores the saturated value, so accumulation sticks at max until acc_clr.
- Undefined: modulo wrap as described above, with ovf=carry.
- Ports and latency are identical either way.

Decomposition:
- Package add_pipe_pkg: localparam for the stage payload width (BIT_WIDTH+1), and a typedef for the stage payload struct {y, ovf} parametrised by width.
- Sub-module pipe_stage: one elastic register stage (valid, payload, ready-in/out, async active-high reset), instantiated DEPTH times with a generate loop.
- The adder, accumulator and SAT logic stay in the add_pipe top.

Test Plan:
- BIT_WIDTH=8, DEPTH=2, out_ready=1, acc_mode=0: feed a0=3,a1=4 -> y=7, ovf=0 exactly 2 cycles after presentation. Then a0=200,a1=100 -> y=44, ovf=1; with ADD_PIPE_SAT_EN -> y=255, ovf=1.
- Accumulate: acc_mode=1, acc_clr=1 with a0=10, then acc_clr=0 with a0=20, then a0=30 -> y sequence 10, 30, 60.
- Back-pressure: stream 1..6 (a1=0) with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, y=1 held stable. Release out_ready -> outputs 1..6 in order, no loss or duplication.
- Simultaneous: full pipeline with out_ready=1 and continuous in_valid -> in_ready stays 1 and one result per cycle.
- Async reset: assert rst mid-stream between clock edges -> out_valid=0, y=0, ovf=0 immediately. After release, an acc_mode=1 beat with a0=5, acc_clr=0 -> y=5 (acc was cleared).
- Random stress, DEPTH=1 and DEPTH=4: random in_valid/out_ready against a scoreboard model -> all results match in order, including ovf.
